mem_reader: RTL and testbench
=============================

Name: mem_reader

Overview:
- Read-side master for the simple dual-port memory (registered read, 1-cycle latency).
- Accepts a burst request (start address, length) and drives the memory read address.
- Returns read data as a valid/ready stream with a last marker, with full backpressure support.
- Feeds memory contents (matrix rows / vector words) into downstream MVM datapath stages.

Parameters:
DATAW, 8, memory word width
DEPTH, 512, memory depth in words
ADDRW, $clog2(DEPTH), address width
LENW, ADDRW+1, burst length width (max length DEPTH)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous reset, active-low
req_valid  input  1  burst request valid
req_ready  output  1  block can accept a request (high only in IDLE)
req_addr  input  ADDRW  burst start address
req_len  input  LENW  burst length in words
mem_raddr  output  ADDRW  memory read address (registered)
mem_rdata  input  DATAW  memory read data, valid one cycle after address issue
o_valid  output  1  output word valid
o_ready  input  1  downstream accepts word
o_data  output  DATAW  output word
o_last  output  1  marks final word of burst
busy  output  1  burst in progress (state != IDLE)

Behaviour:
- Reset (rst_n low, async): state IDLE; fifo empty; inflight 0.
- Reset output values: req_ready=1, o_valid=0, o_last=0, o_data=0, mem_raddr=0, busy=0.
- Reset mid-burst: all in-progress words are discarded, with no partial output after release.
- States and transitions:
  - IDLE: req_ready=1. On req_valid&&req_ready: latch addr and remaining count (remaining=req_len). If req_len!=0, go to READ; if req_len==0, consume the request, emit nothing, stay IDLE.
  - READ: issue reads. issue = (count + inflight - pop) < 2, where pop = o_valid&&o_ready. On issue: mem_raddr presents addr this cycle; at the edge addr <= addr+1 (mod DEPTH, wraps DEPTH-1 -> 0) and remaining decrements. On the issue with remaining==1, go to DRAIN.
  - DRAIN: no issue. Return to IDLE when fifo empty and inflight==0, evaluated after the final pop.
- Pipeline tracking:
  - inflight <= issue.
  - last_inflight <= issue && remaining==1.
  - When inflight==1, mem_rdata plus last_inflight is written into the 2-entry FIFO at the next edge.
- Output side:
  - o_valid = fifo not empty; o_data/o_last come from the FIFO head.
  - o_data and o_last are held stable while o_valid && !o_ready.
  - No word is lost or duplicated.
  - The FIFO never overflows; the credit rule guarantees count+inflight <= 2.
- Latency and throughput:
  - Handshake at edge E0 -> first issue in the cycle after E0 -> first o_valid two cycles after that.
  - With o_ready held high: one word per cycle, no bubbles between words of a burst.
- Requests: req_ready=0 in READ and DRAIN; req_valid is ignored there. A new request is accepted no earlier than the cycle after returning to IDLE.
- Same-cycle FIFO push and pop is allowed when count==2 only if a pop also occurs; the credit rule prevents a push into a full FIFO without a pop.
- mem_raddr is registered. It holds its last value when no issue occurs.

Decomposition:
- Package mem_reader_pkg:
  - state enum typedef {IDLE, READ, DRAIN}
  - localparam FIFO_DEPTH=2
- Sub-module mem_reader_fifo:
  - 2-entry FIFO of {last, data}, parameterised on DATAW
  - ports: push, pop, count, head outputs
  - asynchronous active-low reset

Test Plan:
1. Preload mem[i]=i; request addr=5 len=4, o_ready=1 -> o_data 5,6,7,8 on consecutive cycles; o_last only on 8; first o_valid two cycles after first issue; busy falls after last pop.
2. Wrap: addr=510 len=4 (DEPTH=512) -> mem_raddr 510,511,0,1; o_data mem[510],mem[511],mem[0],mem[1].
3. Backpressure: addr=0 len=8, o_ready low for 5 cycles mid-burst then random toggling -> exactly 0..7 in order; o_data stable while stalled; issue stops with count+inflight=2.
4. Zero length: req_len=0 -> request consumed in one cycle, o_valid never asserts, busy stays 0, req_ready stays 1.
5. Reset mid-burst: assert rst_n low after 3 words -> o_valid=0, req_ready=1, busy=0 immediately; after release, request addr=20 len=2 returns mem[20],mem[21] with correct o_last.
6. Back-to-back: req_valid held high with two queued requests -> req_ready=0 during the first burst; the second burst starts only after the first o_last is popped; no interleaving.

Source files
------------

// File: rtl/mem_reader_pkg.sv
// Shared types and sizing for the memory read-side burst master.
package mem_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNTW       = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/mem_reader_fifo.sv
// Two-entry return FIFO of {last, data}; entry 0 is the registered head.
module mem_reader_fifo
  import mem_reader_pkg::*;
#(
  parameter int unsigned DATAW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DATAW-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic [CNTW-1:0]  count,
  output logic             valid,
  output logic [DATAW-1:0] head_data,
  output logic             head_last
);

  logic [DATAW-1:0] tail_data;
  logic             tail_last;
  logic             pop_ok_c;
  logic             push_ok_c;
  logic [CNTW-1:0]  count_next_c;

  // A push into a full FIFO is only legal alongside a pop.
  always_comb begin
    pop_ok_c     = pop && (count != '0);
    push_ok_c    = push && ((count < CNTW'(FIFO_DEPTH)) || pop_ok_c);
    count_next_c = count + CNTW'(push_ok_c) - CNTW'(pop_ok_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      valid     <= 1'b0;
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      count <= count_next_c;
      valid <= (count_next_c != '0);
      if (pop_ok_c) begin
        if (count == CNTW'(2)) begin
          head_data <= tail_data;
          head_last <= tail_last;
        end else if (push_ok_c) begin
          head_data <= push_data;
          head_last <= push_last;
        end
      end else if (push_ok_c && count == '0) begin
        head_data <= push_data;
        head_last <= push_last;
      end
      if (push_ok_c && ((count == CNTW'(1) && !pop_ok_c) || (count == CNTW'(2) && pop_ok_c))) begin
        tail_data <= push_data;
        tail_last <= push_last;
      end
    end
  end

endmodule

// File: rtl/mem_reader.sv
// Burst read master: issues sequential reads to a 1-cycle-latency memory
// and returns the words as a valid/ready stream with a last marker.
module mem_reader
  import mem_reader_pkg::*;
#(
  parameter int unsigned DATAW = 8,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned ADDRW = $clog2(DEPTH),
  parameter int unsigned LENW  = ADDRW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ADDRW-1:0] req_addr,
  input  logic [LENW-1:0]  req_len,
  output logic [ADDRW-1:0] mem_raddr,
  input  logic [DATAW-1:0] mem_rdata,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [DATAW-1:0] o_data,
  output logic             o_last,
  output logic             busy
);

  state_t          state;
  state_t          state_next;
  logic [LENW-1:0] remaining;
  logic            inflight;
  logic            last_inflight;
  logic [CNTW-1:0] count;
  logic            pop_c;
  logic            issue_c;
  logic            accept_c;
  logic [2:0]      pending_c;
  logic [ADDRW-1:0] addr_inc_c;

  // Words held or on their way back; a new read needs a free FIFO slot.
  always_comb begin
    pop_c      = o_valid && o_ready;
    pending_c  = 3'(count) + 3'(inflight) - 3'(pop_c);
    addr_inc_c = (mem_raddr == ADDRW'(DEPTH - 1)) ? '0 : mem_raddr + ADDRW'(1);
  end

  always_comb begin
    state_next = state;
    issue_c    = 1'b0;
    accept_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          if (req_len != '0) state_next = READ;
        end
      end
      READ: begin
        if (pending_c < 3'd2) begin
          issue_c = 1'b1;
          if (remaining == LENW'(1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (count == '0 && !inflight) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      req_ready <= (state_next == IDLE);
      busy      <= (state_next != IDLE);
    end
  end

  // mem_raddr doubles as the burst address pointer, so the issue cycle
  // already presents the address and data returns in the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_raddr     <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      last_inflight <= 1'b0;
    end else begin
      inflight      <= issue_c;
      last_inflight <= issue_c && (remaining == LENW'(1));
      if (accept_c) begin
        mem_raddr <= req_addr;
        remaining <= req_len;
      end else if (issue_c) begin
        mem_raddr <= addr_inc_c;
        remaining <= remaining - LENW'(1);
      end
    end
  end

  mem_reader_fifo #(
    .DATAW(DATAW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight),
    .push_data(mem_rdata),
    .push_last(last_inflight),
    .pop      (o_ready),
    .count    (count),
    .valid    (o_valid),
    .head_data(o_data),
    .head_last(o_last)
  );

endmodule

// File: tb/tb_mem_reader.sv
// Self-checking bench for mem_reader: memory model, expected-word queue
// built from accepted requests, and randomized downstream backpressure.
module tb_mem_reader;

  localparam int unsigned DATAW = 8;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned ADDRW = 9;
  localparam int unsigned LENW  = 10;

  typedef struct packed {
    logic             last;
    logic [DATAW-1:0] data;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [ADDRW-1:0] req_addr;
  logic [LENW-1:0]  req_len;
  logic [ADDRW-1:0] mem_raddr;
  logic [DATAW-1:0] mem_rdata;
  logic             o_valid;
  logic             o_ready;
  logic [DATAW-1:0] o_data;
  logic             o_last;
  logic             busy;

  logic [DATAW-1:0] mem [DEPTH];
  exp_t             exp_q[$];
  int               pop_cyc_q[$];
  int               errors;
  int               checks;
  int               cyc;
  int               acc_cyc;
  int               npops;
  int               ready_mode;
  logic             prev_stall;
  logic [DATAW-1:0] prev_data;
  logic             prev_last;

  mem_reader #(
    .DATAW(DATAW), .DEPTH(DEPTH), .ADDRW(ADDRW), .LENW(LENW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .o_valid(o_valid), .o_ready(o_ready),
    .o_data(o_data), .o_last(o_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_rdata <= mem[mem_raddr];

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       o_ready = 1'b1;
      1:       o_ready = 1'b0;
      default: o_ready = 1'($urandom);
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Outputs sampled mid-cycle; the expected stream follows accepted requests.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        check("accept_while_pending", 32'(exp_q.size()), 32'd0);
        for (int k = 0; k < int'(req_len); k++) begin
          exp_q.push_back({k == int'(req_len) - 1, mem[(int'(req_addr) + k) % DEPTH]});
        end
        acc_cyc = cyc;
      end
      if (busy && req_valid) check("req_ready_busy", 32'(req_ready), 32'd0);
      if (prev_stall) begin
        check("stall_valid", 32'(o_valid), 32'd1);
        check("stall_data", 32'(o_data), 32'(prev_data));
        check("stall_last", 32'(o_last), 32'(prev_last));
      end
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_word", 32'(o_valid), 32'd0);
        end else if (o_ready) begin
          exp_t e;
          e = exp_q.pop_front();
          check("o_data", 32'(o_data), 32'(e.data));
          check("o_last", 32'(o_last), 32'(e.last));
          pop_cyc_q.push_back(cyc);
          npops++;
        end
      end
      prev_stall = o_valid && !o_ready;
      prev_data  = o_data;
      prev_last  = o_last;
    end
  end

  task automatic do_req(input int a, input int l, input bit keep);
    bit ok;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = ADDRW'(a);
    req_len   = LENW'(l);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("req_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 32'(busy) + 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_pops(input int target);
    for (int i = 0; i < 200 && npops < target; i++) @(negedge clk);
    if (npops < target) check("pop_timeout", 32'(npops), 32'(target));
  endtask

  initial begin
    int base;
    errors = 0; checks = 0; cyc = 0; npops = 0; acc_cyc = 0;
    ready_mode = 0; o_ready = 1'b1; prev_stall = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_len = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DATAW'(i);
    rst_n = 1'b0;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_last", 32'(o_last), 32'd0);
    check("rst_o_data", 32'(o_data), 32'd0);
    check("rst_mem_raddr", 32'(mem_raddr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Basic burst: latency and one word per cycle.
    pop_cyc_q.delete();
    do_req(5, 4, 1'b0);
    wait_idle();
    check("t1_words", 32'(pop_cyc_q.size()), 32'd4);
    if (pop_cyc_q.size() == 4) begin
      check("t1_latency", 32'(pop_cyc_q[0] - acc_cyc), 32'd3);
      for (int i = 1; i < 4; i++) check("t1_no_bubble", 32'(pop_cyc_q[i] - pop_cyc_q[i-1]), 32'd1);
    end

    // Address wrap at the top of memory.
    do_req(510, 4, 1'b0);
    wait_idle();

    // Backpressure: stall mid-burst, then random ready.
    base = npops;
    do_req(0, 8, 1'b0);
    wait_pops(base + 2);
    ready_mode = 1;
    repeat (5) @(posedge clk);
    ready_mode = 2;
    wait_idle();
    ready_mode = 0;

    // Zero-length request leaves the block idle.
    do_req(100, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_o_valid", 32'(o_valid), 32'd0);
      check("t4_req_ready", 32'(req_ready), 32'd1);
    end

    // Reset in the middle of a burst.
    base = npops;
    do_req(40, 10, 1'b0);
    wait_pops(base + 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_o_valid", 32'(o_valid), 32'd0);
    check("t5_req_ready", 32'(req_ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    base = npops;
    do_req(20, 2, 1'b0);
    wait_idle();
    check("t5_words", 32'(npops - base), 32'd2);

    // Back-to-back requests with req_valid held high.
    do_req(300, 6, 1'b1);
    do_req(100, 3, 1'b0);
    wait_idle();

    // Random bursts under random backpressure.
    ready_mode = 2;
    for (int n = 0; n < 10; n++) begin
      do_req(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 20)), n[0]);
    end
    req_valid = 1'b0;
    wait_idle();
    ready_mode = 0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
